iter_multiplier: RTL and testbench
==================================

# iter_multiplier

Multi-cycle radix-2 shift-add multiplier that serves as the responder on the EX stage's multiply request interface. It replaces the single-cycle product path for MULT/MULTU/MADD/MADDU/MSUB/MSUBU. EX supplies the operands and the current HI/LO value. The block holds the pipeline via a stall request and returns a 64-bit {HI,LO} result that EX forwards to MEM as HI/LO write data.

## Interface
- No parameters. Data width is fixed at 32 bits; the result is 64 bits.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; the block is held in reset while rst is 0.
- start  in  1  multiply request from EX; held high by EX until the operation completes.
- cancel  in  1  abort the current operation (pipeline flush).
- op_signed  in  1  1 = signed operands, 0 = unsigned.
- op_acc  in  1  1 = accumulate into {hi_in, lo_in} (MADD/MSUB family).
- op_sub  in  1  with op_acc: 1 = subtract the product, 0 = add it.
- operand_1  in  32  multiplicand (rs).
- operand_2  in  32  multiplier (rt).
- hi_in  in  32  current HI value, after forwarding.
- lo_in  in  32  current LO value, after forwarding.
- mult_stall_request  out  1  request that EX and earlier stages stall.
- result_valid  out  1  result is valid.
- result_mult  out  64  {HI, LO} result.

## Operation
- States: IDLE, CALC, ACC, DONE. Reset forces IDLE.
- Reset values: mult_stall_request=0, result_valid=0, result_mult=0, iteration counter=0.
- IDLE
  - When start=1 and cancel=0, latch op_signed, op_acc, op_sub, hi_in and lo_in.
  - Latch |operand_1| and |operand_2|. Two's-complement negation is applied only when op_signed=1 and bit 31 is set.
  - Latch neg = op_signed & (operand_1[31] ^ operand_2[31]).
  - Clear the 64-bit accumulator and the counter, then go to CALC.
- CALC: 32 iterations, one per cycle, counter 0..31.
  - If multiplier bit[counter] is 1, add (multiplicand << counter) to the accumulator. All arithmetic is 64-bit unsigned.
  - After iteration 31, go to ACC. The accumulator holds the unsigned magnitude product.
- ACC
  - prod = neg ? -acc : acc, computed mod 2^64.
  - If op_acc: result = {hi,lo} + prod, or {hi,lo} − prod when op_sub. Wrap mod 2^64; there is no overflow flag.
  - Otherwise result = prod.
  - Register the result and go to DONE.
- DONE
  - result_valid=1 and result_mult is stable.
  - Remains in DONE while start=1. This covers EX being stalled by another source, such as the divider.
  - Goes to IDLE on the first cycle with start=0. result_valid clears on that transition.
- mult_stall_request is combinational:
  - 1 when (IDLE & start & ~cancel), or in CALC, or in ACC.
  - 0 in DONE and in IDLE without a request.
- cancel=1 in any state forces IDLE on the next edge and suppresses result_valid. cancel has priority over start.
- Operand inputs are ignored after the IDLE capture. Changes mid-operation have no effect.
- result_mult keeps its last value when not in DONE. Consumers qualify it with result_valid.

## Timing
- Cycle 0: start is seen in IDLE; stall is asserted combinationally in the same cycle.
- Cycles 1–32: CALC.
- Cycle 33: ACC.
- Cycle 34: DONE, with result_valid=1 and mult_stall_request=0.
- Total latency is 34 cycles from start to result_valid. The pipeline stalls for 34 cycles, cycles 0–33.
- Back-to-back operations: start must be low for at least one cycle (the DONE→IDLE transition) before a new request is accepted.
- Asynchronous reset mid-operation: all outputs drop to their reset values immediately; no result is produced.
- A cancel at the same edge as the CALC→ACC or ACC→DONE transition wins: the next state is IDLE.

## Configuration
- MULT_ACC_EN defined:
  - ACC state is present and MADD/MSUB are supported as described above.
  - Latency is 34 cycles.
- MULT_ACC_EN undefined:
  - ACC state is removed; op_acc, op_sub, hi_in and lo_in are ignored.
  - Sign correction is folded into the last CALC cycle, and CALC goes directly to DONE.
  - Latency is 33 cycles, with result_valid in cycle 33.

## Test plan
- Unsigned: 0xFFFFFFFF × 0xFFFFFFFF → result_mult=0xFFFFFFFE_00000001. Stall is high for cycles 0–33 and valid is high in cycle 34.
- Signed: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000_00000001. Signed 0x80000000 × 0x80000000 → 0x40000000_00000000.
- Accumulate (MULT_ACC_EN): MADDU with hi:lo=0x00000000_FFFFFFFF, 1×1 → 0x00000001_00000000. MSUB with hi:lo=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
- Hold in DONE: keep start high for 5 cycles after valid → result_valid stays 1 and the value is stable. Drop start → IDLE next cycle and valid=0.
- cancel=1 in cycle 10 → stall drops in cycle 11 and result_valid never rises. An immediate new start with 3×5 → 15 after the full latency.
- rst=0 in cycle 20 → outputs go to zero asynchronously. After reset is released, a fresh 7×6 request returns 42.

Source files
------------

// File: rtl/iter_multiplier_if.sv
// Multiply request interface between the EX stage (master) and the
// iterative multiplier (slave).
interface iter_multiplier_if;
    logic        start;
    logic        cancel;
    logic        op_signed;
    logic        op_acc;
    logic        op_sub;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        mult_stall_request;
    logic        result_valid;
    logic [63:0] result_mult;

    modport master (
        output start, cancel, op_signed, op_acc, op_sub,
        output operand_1, operand_2, hi_in, lo_in,
        input  mult_stall_request, result_valid, result_mult
    );

    modport slave (
        input  start, cancel, op_signed, op_acc, op_sub,
        input  operand_1, operand_2, hi_in, lo_in,
        output mult_stall_request, result_valid, result_mult
    );
endinterface

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, answering
// the EX stage multiply request. Returns a 64-bit {HI,LO} result.
// Optional feature macro: MULT_ACC_EN adds the ACC state and MADD/MSUB
// accumulation into {hi_in,lo_in}; without it the sign fix-up happens in
// the last CALC cycle and accumulate controls are ignored.
module iter_multiplier (
    input  logic              clk,
    input  logic              rst,
    iter_multiplier_if.slave  bus
);

`ifdef MULT_ACC_EN
    typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [63:0] result_q, result_d;
    logic        stall;

    logic [31:0] abs_1;
    logic [31:0] abs_2;
    logic [63:0] partial;

`ifdef MULT_ACC_EN
    logic        op_acc_q, op_acc_d;
    logic        op_sub_q, op_sub_d;
    logic [63:0] hilo_q, hilo_d;
    logic [63:0] prod;
`else
    logic        unused_acc_inputs;
    assign unused_acc_inputs = ^{bus.op_acc, bus.op_sub, bus.hi_in, bus.lo_in};
`endif

    // Operand magnitudes; negation only for signed ops with the sign bit set.
    always_comb begin
        abs_1 = (bus.op_signed && bus.operand_1[31]) ? (~bus.operand_1 + 32'd1) : bus.operand_1;
        abs_2 = (bus.op_signed && bus.operand_2[31]) ? (~bus.operand_2 + 32'd1) : bus.operand_2;
    end

    // Accumulator value after the current iteration's conditional add.
    always_comb begin
        partial = acc_q;
        if (mplier_q[cnt_q]) begin
            partial = acc_q + ({32'h0, mcand_q} << cnt_q);
        end
    end

    // Next-state, datapath updates and stall request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        stall    = 1'b0;
`ifdef MULT_ACC_EN
        op_acc_d = op_acc_q;
        op_sub_d = op_sub_q;
        hilo_d   = hilo_q;
        prod     = neg_q ? (~acc_q + 64'd1) : acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    stall    = 1'b1;
                    mcand_d  = abs_1;
                    mplier_d = abs_2;
                    neg_d    = bus.op_signed & (bus.operand_1[31] ^ bus.operand_2[31]);
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_ACC_EN
                    op_acc_d = bus.op_acc;
                    op_sub_d = bus.op_sub;
                    hilo_d   = {bus.hi_in, bus.lo_in};
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                acc_d = partial;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
`ifdef MULT_ACC_EN
                    state_d  = ACC;
`else
                    // Sign fix-up uses the final partial sum so DONE follows directly.
                    result_d = neg_q ? (~partial + 64'd1) : partial;
                    state_d  = DONE;
`endif
                end
            end
`ifdef MULT_ACC_EN
            ACC: begin
                stall = 1'b1;
                if (op_acc_q) begin
                    result_d = op_sub_q ? (hilo_q - prod) : (hilo_q + prod);
                end else begin
                    result_d = prod;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.cancel) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
`ifdef MULT_ACC_EN
            op_acc_q <= 1'b0;
            op_sub_q <= 1'b0;
            hilo_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
`ifdef MULT_ACC_EN
            op_acc_q <= op_acc_d;
            op_sub_q <= op_sub_d;
            hilo_q   <= hilo_d;
`endif
        end
    end

    // Stall is gated by reset so a pending start cannot raise it while held in reset.
    assign bus.mult_stall_request = stall & rst;
    assign bus.result_valid       = (state_q == DONE);
    assign bus.result_mult        = result_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed self-checking bench for iter_multiplier.
module tb_iter_multiplier;

`ifdef MULT_ACC_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    iter_multiplier_if bus ();

    iter_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion; operands are scrambled
    // after capture to show they are not re-sampled.
    task automatic run_op(input logic sgn, input logic acc, input logic sub,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, input logic [63:0] exp,
                          input int hold, input string tag);
        logic ok;
        bus.op_signed = sgn;
        bus.op_acc    = acc;
        bus.op_sub    = sub;
        bus.operand_1 = a;
        bus.operand_2 = b;
        bus.hi_in     = hilo[63:32];
        bus.lo_in     = hilo[31:0];
        bus.cancel    = 1'b0;
        bus.start     = 1'b1;
        #1;
        chk({63'h0, bus.mult_stall_request}, 64'd1, {tag, " stall c0"});
        ok = 1'b1;
        for (int c = 1; c < LAT; c++) begin
            tick();
            if (c == 1) begin
                bus.operand_1 = $urandom;
                bus.operand_2 = $urandom;
                bus.hi_in     = $urandom;
                bus.lo_in     = $urandom;
                bus.op_signed = ~sgn;
                bus.op_acc    = ~acc;
                bus.op_sub    = ~sub;
                #1;
            end
            if (bus.mult_stall_request !== 1'b1 || bus.result_valid !== 1'b0) ok = 1'b0;
        end
        chk({63'h0, ok}, 64'd1, {tag, " busy window"});
        tick();
        chk({63'h0, bus.result_valid}, 64'd1, {tag, " valid"});
        chk({63'h0, bus.mult_stall_request}, 64'd0, {tag, " stall done"});
        chk(bus.result_mult, exp, {tag, " result"});
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({63'h0, bus.result_valid}, 64'd1, {tag, " hold valid"});
            chk(bus.result_mult, exp, {tag, " hold result"});
        end
        bus.start = 1'b0;
        tick();
        chk({63'h0, bus.result_valid}, 64'd0, {tag, " valid clear"});
        chk(bus.result_mult, exp, {tag, " result kept"});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_acc    = 1'b0;
        bus.op_sub    = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.hi_in     = '0;
        bus.lo_in     = '0;

        tick();
        tick();
        chk({63'h0, bus.mult_stall_request}, 64'd0, "reset stall");
        chk({63'h0, bus.result_valid}, 64'd0, "reset valid");
        chk(bus.result_mult, 64'h0, "reset result");
        rst = 1'b1;
        tick();

        run_op(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,
               64'hFFFF_FFFE_0000_0001, 0, "mulu max");
        run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,
               64'h0000_0000_0000_0001, 0, "mul m1");
        run_op(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h0,
               64'h4000_0000_0000_0000, 5, "mul minint");
        run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 64'h0,
               64'hFFFF_FFFF_FFFF_FFF1, 0, "mul neg");
        run_op(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0,
               64'h0000_0001_2345_6780, 0, "mulu shift");
`ifdef MULT_ACC_EN
        run_op(1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF,
               64'h0000_0001_0000_0000, 0, "maddu");
        run_op(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF, 0, "msub");
        run_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 64'd10,
               64'd4, 0, "madd neg");
`else
        run_op(1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF,
               64'd1, 0, "maddu ignored");
        run_op(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 64'h0,
               64'd1, 0, "msub ignored");
        run_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 64'd10,
               64'hFFFF_FFFF_FFFF_FFFA, 0, "madd neg ignored");
`endif

        // Cancel in cycle 10, then an immediate new request.
        bus.op_signed = 1'b0;
        bus.op_acc    = 1'b0;
        bus.op_sub    = 1'b0;
        bus.operand_1 = 32'd100;
        bus.operand_2 = 32'd100;
        bus.start     = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        bus.cancel = 1'b1;
        #1;
        chk({63'h0, bus.mult_stall_request}, 64'd1, "cancel c10 stall");
        tick();
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        #1;
        chk({63'h0, bus.mult_stall_request}, 64'd0, "cancel c11 stall");
        chk({63'h0, bus.result_valid}, 64'd0, "cancel c11 valid");
        tick();
        chk({63'h0, bus.result_valid}, 64'd0, "cancel c12 valid");
        run_op(1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 64'h0, 64'd15, 0, "after cancel");

        // Asynchronous reset in cycle 20 of an operation.
        bus.op_signed = 1'b0;
        bus.operand_1 = 32'h0000_DEAD;
        bus.operand_2 = 32'h0000_BEEF;
        bus.start     = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b0;
        #1;
        chk({63'h0, bus.mult_stall_request}, 64'd0, "async rst stall");
        chk({63'h0, bus.result_valid}, 64'd0, "async rst valid");
        chk(bus.result_mult, 64'h0, "async rst result");
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk({63'h0, bus.result_valid}, 64'd0, "post rst valid");
        run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 64'h0, 64'd42, 0, "post rst 7x6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
